// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
// Shared constants and types for the pixel fetch streamer.
//   IMG_W / IMG_H   default frame geometry (pixels per row / rows per frame)
//   IMG_PIXELS      default pixels per frame
//   ADDR_W          byte address width into pixel memory
//   X_W / Y_W       column / row tag widths
//   PIX_W           pixel width
//   fetchState_t    streamer FSM state encoding
//   lastAddr()      address of the final pixel of a w x h frame
// ---------------------------------------------------------------------------
package pixel_pkg;

    localparam int IMG_W      = 640;
    localparam int IMG_H      = 480;
    localparam int IMG_PIXELS = IMG_W * IMG_H;   // 307200
    localparam int ADDR_W     = 20;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int PIX_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetchState_t;

    function automatic logic [ADDR_W-1:0] lastAddr(input int w, input int h);
        return ADDR_W'(w * h - 1);
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// ---------------------------------------------------------------------------
// pixel_coord_counter
// Raster-order address and column/row counter for one frame.
//   clk, rst   clock, asynchronous active-high reset
//   clear      restart at address 0, column 0, row 0
//   advance    step to the next pixel (ignored once the last address is hit)
//   addr       current byte address
//   x, y       column / row of the pixel at addr
//   last       addr is the final pixel of the frame
// ---------------------------------------------------------------------------
module pixel_coord_counter #(
    parameter int IMG_W = pixel_pkg::IMG_W,
    parameter int IMG_H = pixel_pkg::IMG_H
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         advance,
    output logic [pixel_pkg::ADDR_W-1:0] addr,
    output logic [pixel_pkg::X_W-1:0]    x,
    output logic [pixel_pkg::Y_W-1:0]    y,
    output logic                         last
);

    import pixel_pkg::ADDR_W;
    import pixel_pkg::X_W;
    import pixel_pkg::lastAddr;

    localparam logic [ADDR_W-1:0] ADDR_MAX = lastAddr(IMG_W, IMG_H);
    localparam logic [X_W-1:0]    X_MAX    = X_W'(IMG_W - 1);

    assign last = (addr == ADDR_MAX);

    // Saturate on the last pixel so the address can never run past the
    // frame, even if the caller keeps advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            x    <= '0;
            y    <= '0;
        end else if (clear) begin
            addr <= '0;
            x    <= '0;
            y    <= '0;
        end else if (advance && !last) begin
            addr <= addr + 1'b1;
            if (x == X_MAX) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_fetch_streamer.sv
// ---------------------------------------------------------------------------
// pixel_fetch_streamer
// Reads one frame of 8-bit pixels from a combinational-read memory in raster
// order and presents them on a valid/ready stream tagged with x/y/last.
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle request to stream a frame (ignored while busy)
//   abort        cancel the frame in progress (no done pulse)
//   mem_addr     byte address into pixel memory
//   mem_data     read data for mem_addr, bits [7:0] used
//   pix_data     pixel value; pix_x / pix_y / pix_last tag it
//   pix_valid    output stream valid
//   pix_ready    consumer accepts the presented pixel
//   busy         FSM not in IDLE
//   done         one-cycle pulse after the final pixel is accepted
// ---------------------------------------------------------------------------
module pixel_fetch_streamer #(
    parameter int IMG_W = pixel_pkg::IMG_W,
    parameter int IMG_H = pixel_pkg::IMG_H
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic [pixel_pkg::ADDR_W-1:0] mem_addr,
    input  logic [31:0]                  mem_data,
    output logic [pixel_pkg::PIX_W-1:0]  pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [pixel_pkg::X_W-1:0]    pix_x,
    output logic [pixel_pkg::Y_W-1:0]    pix_y,
    output logic                         pix_last,
    output logic                         busy,
    output logic                         done
);

    import pixel_pkg::ADDR_W;
    import pixel_pkg::X_W;
    import pixel_pkg::Y_W;
    import pixel_pkg::PIX_W;
    import pixel_pkg::fetchState_t;
    import pixel_pkg::IDLE;
    import pixel_pkg::FETCH;
    import pixel_pkg::DRAIN;

    fetchState_t       state, stateNext;
    logic              primed;
    logic              load;
    logic              handshake;
    logic              clearCnt;
    logic              doneNext;
    logic [ADDR_W-1:0] cntAddr;
    logic [X_W-1:0]    cntX;
    logic [Y_W-1:0]    cntY;
    logic              cntLast;
    logic              unusedMemHi;

    assign unusedMemHi = ^mem_data[31:PIX_W];
    assign handshake   = pix_valid && pix_ready;
    assign busy        = (state != IDLE);
    assign mem_addr    = cntAddr;

    // -----------------------------------------------------------------------
    // FSM next-state and per-cycle strobes
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        clearCnt  = 1'b0;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = FETCH;
                    clearCnt  = 1'b1;
                end
            end
            FETCH: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (primed && (!pix_valid || pix_ready)) begin
                    load = 1'b1;
                    if (cntLast) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (handshake) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // The first FETCH cycle only presents address 0; capture starts one
    // cycle later so the memory sees a settled address before the first
    // pixel is taken, giving a fixed two-cycle start-to-valid latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) primed <= 1'b0;
        else     primed <= (state == FETCH);
    end

    // -----------------------------------------------------------------------
    // Output pixel register; abort wins over a coincident load/handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else if (busy && abort) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else if (load) begin
            pix_data  <= mem_data[PIX_W-1:0];
            pix_x     <= cntX;
            pix_y     <= cntY;
            pix_valid <= 1'b1;
            pix_last  <= cntLast;
        end else if (handshake) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= doneNext;
    end

    pixel_coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) coordCounter (
        .clk     (clk),
        .rst     (rst),
        .clear   (clearCnt),
        .advance (load),
        .addr    (cntAddr),
        .x       (cntX),
        .y       (cntY),
        .last    (cntLast)
    );

endmodule

// File: tb/tb_pixel_fetch_streamer.sv
// ---------------------------------------------------------------------------
// tb_pixel_fetch_streamer
// Frames are 640 wide with a reduced height so whole-frame scenarios stay
// short; row wrap and the last-pixel position are still exercised.
// ---------------------------------------------------------------------------
module tb_pixel_fetch_streamer;

    localparam int IMG_W = 640;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = $clog2(NPIX);

    typedef struct packed {
        logic [7:0] d;
        logic [9:0] x;
        logic [8:0] y;
        logic       l;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_last;
    logic        busy;
    logic        done;

    logic [7:0]  memBytes [0:NPIX-1];
    logic [7:0]  memByte;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    always_comb begin
        memByte = 8'h00;
        if (int'(mem_addr) < NPIX) memByte = memBytes[mem_addr[AW-1:0]];
    end
    // Upper bits carry address-dependent junk that must never reach pix_data.
    assign mem_data = {4'hA, mem_addr, memByte};

    pixel_fetch_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    // Reference: pixel i of the frame in raster order.
    function automatic pix_t expPix(input int i);
        pix_t p;
        logic [AW-1:0] a;
        a   = AW'(i);
        p.d = memBytes[a];
        p.x = 10'(i % IMG_W);
        p.y = 9'(i / IMG_W);
        p.l = (i == NPIX - 1);
        return p;
    endfunction

    function automatic pix_t obsPix();
        return {pix_data, pix_x, pix_y, pix_last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        checks++;
        if ({mem_addr, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_values: got addr=%h data=%h x=%0d y=%0d v=%b l=%b busy=%b done=%b, want all 0",
                     mem_addr, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || pix_valid !== 1'b0) begin
                fails++;
                $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, pix_valid);
            end
        end
    endtask

    task automatic test_full_frame();
        int idx = 0, cyc = 0, gaps = 0, doneCnt = 0;
        pix_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        checks++;
        if (mem_addr !== 20'd0 || pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_n1: addr=%0d valid=%b, want 0 0", mem_addr, pix_valid);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b1 || obsPix() !== expPix(0)) begin
            fails++;
            $display("FAIL latency_n2: valid=%b pix=%h, want 1 %h", pix_valid, obsPix(), expPix(0));
        end
        while (idx < NPIX && cyc < NPIX + 50) begin
            if (pix_valid) begin
                checks++;
                if (obsPix() !== expPix(idx)) begin
                    fails++;
                    $display("FAIL full_pixel[%0d]: got %h want %h", idx, obsPix(), expPix(idx));
                end
                if (idx == IMG_W) begin
                    checks++;
                    if (pix_x !== 10'd0 || pix_y !== 9'd1) begin
                        fails++;
                        $display("FAIL row_wrap: x=%0d y=%0d, want 0 1", pix_x, pix_y);
                    end
                end
                idx++;
            end else begin
                gaps++;
            end
            if (done) doneCnt++;
            tick(); cyc++;
        end
        checks++;
        if (idx != NPIX || gaps != 0) begin
            fails++;
            $display("FAIL full_count: pixels=%0d gaps=%0d, want %0d 0", idx, gaps, NPIX);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_done: done=%b busy=%b valid=%b, want 1 0 0", done, busy, pix_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (done) doneCnt++;
            tick();
        end
        checks++;
        if (doneCnt != 1) begin
            fails++;
            $display("FAIL full_done_once: pulses=%0d want 1", doneCnt);
        end
    endtask

    task automatic test_stall();
        int idx = 0, cyc = 0;
        pix_t held;
        pix_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        while (idx < 100 && cyc < 200) begin
            if (pix_valid) begin
                checks++;
                if (obsPix() !== expPix(idx)) begin
                    fails++;
                    $display("FAIL stall_pre[%0d]: got %h want %h", idx, obsPix(), expPix(idx));
                end
                idx++;
            end
            tick(); cyc++;
        end
        pix_ready = 1'b0;
        held = expPix(100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pix_valid !== 1'b1 || obsPix() !== held || mem_addr !== 20'd101) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b pix=%h addr=%0d, want 1 %h 101",
                         i, pix_valid, obsPix(), mem_addr, held);
            end
            tick();
        end
        pix_ready = 1'b1;
        cyc = 0;
        while (idx < NPIX && cyc < NPIX + 50) begin
            if (pix_valid) begin
                checks++;
                if (obsPix() !== expPix(idx)) begin
                    fails++;
                    $display("FAIL stall_post[%0d]: got %h want %h", idx, obsPix(), expPix(idx));
                end
                idx++;
            end
            tick(); cyc++;
        end
        checks++;
        if (idx != NPIX || done !== 1'b1) begin
            fails++;
            $display("FAIL stall_end: pixels=%0d done=%b, want %0d 1", idx, done, NPIX);
        end
    endtask

    task automatic test_random_ready();
        int   idx = 0, cyc = 0;
        logic prevStall = 1'b0;
        pix_t prev = '0;
        pix_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        while (idx < NPIX && cyc < 8 * NPIX) begin
            if (prevStall) begin
                checks++;
                if (pix_valid !== 1'b1 || obsPix() !== prev) begin
                    fails++;
                    $display("FAIL rand_hold: valid=%b pix=%h, want 1 %h", pix_valid, obsPix(), prev);
                end
            end
            pix_ready = 1'($urandom_range(0, 1));
            if (pix_valid && pix_ready) begin
                checks++;
                if (obsPix() !== expPix(idx)) begin
                    fails++;
                    $display("FAIL rand_pixel[%0d]: got %h want %h", idx, obsPix(), expPix(idx));
                end
                idx++;
            end
            prevStall = pix_valid && !pix_ready;
            prev      = obsPix();
            tick(); cyc++;
        end
        pix_ready = 1'b0;
        checks++;
        if (idx != NPIX || done !== 1'b1) begin
            fails++;
            $display("FAIL rand_end: pixels=%0d done=%b, want %0d 1", idx, done, NPIX);
        end
        tick();
    endtask

    task automatic test_abort();
        int idx = 0, cyc = 0, doneCnt = 0;
        pix_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        while (idx < 1000 && cyc < 1100) begin
            if (pix_valid) idx++;
            tick(); cyc++;
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b, want 0 0 0", pix_valid, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            if (done) doneCnt++;
            tick();
        end
        checks++;
        if (doneCnt != 0) begin
            fails++;
            $display("FAIL abort_no_done: pulses=%0d want 0", doneCnt);
        end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        checks++;
        if (mem_addr !== 20'd0 || pix_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart_n1: addr=%0d valid=%b busy=%b, want 0 0 1", mem_addr, pix_valid, busy);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b1 || obsPix() !== expPix(0)) begin
            fails++;
            $display("FAIL abort_restart_n2: valid=%b pix=%h, want 1 %h", pix_valid, obsPix(), expPix(0));
        end
        // Abort coincident with an accepted pixel.
        abort = 1'b1; tick(); abort = 1'b0;
        tick();
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_vs_handshake: valid=%b busy=%b done=%b, want 0 0 0", pix_valid, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0, cyc = 0;
        pix_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        while (idx < NPIX && cyc < NPIX + 50) begin
            if (pix_valid) begin
                checks++;
                if (obsPix() !== expPix(idx)) begin
                    fails++;
                    $display("FAIL b2b_pixel[%0d]: got %h want %h", idx, obsPix(), expPix(idx));
                end
                idx++;
            end
            start = (idx == 10);
            tick(); cyc++;
        end
        start = 1'b0;
        checks++;
        if (idx != NPIX || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: pixels=%0d done=%b busy=%b, want %0d 1 0", idx, done, busy, NPIX);
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
        end
        tick();
        checks++;
        if (mem_addr !== 20'd0 || pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_n1: addr=%0d valid=%b, want 0 0", mem_addr, pix_valid);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b1 || obsPix() !== expPix(0)) begin
            fails++;
            $display("FAIL b2b_n2: valid=%b pix=%h, want 1 %h", pix_valid, obsPix(), expPix(0));
        end
        abort = 1'b1; tick(); abort = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        pix_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_addr, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done} !== '0) begin
            fails++;
            $display("FAIL async_reset: addr=%h data=%h x=%0d y=%0d v=%b l=%b busy=%b done=%b, want all 0",
                     mem_addr, pix_data, pix_x, pix_y, pix_valid, pix_last, busy, done);
        end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || pix_valid !== 1'b0) begin
                fails++;
                $display("FAIL async_reset_idle: busy=%b valid=%b, want 0 0", busy, pix_valid);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) memBytes[i] = 8'($urandom);
        test_reset();
        test_full_frame();
        test_stall();
        test_random_ready();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
